// File: rtl/booth_pkg.sv
// Shared types for the radix-2 Booth multiplier.
// FSM states, Booth op codes and the op decode helper.
package booth_pkg;

  localparam int BOOTH_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } st_t;

  typedef enum logic [1:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB
  } op_t;

  // {Q[0],Q_1}: 01 adds M, 10 subtracts M, else no-op
  function automatic op_t booth_op(
    input logic q0,
    input logic q1
  );
    op_t r;
    r = OP_NOP;
    unique case (1'b1)
      (q0 == 1'b0 && q1 == 1'b1): r = OP_ADD;
      (q0 == 1'b1 && q1 == 1'b0): r = OP_SUB;
      default:                    r = OP_NOP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// Combinational add/subtract of M into the A register.
// Width N is the sign-extended accumulator width.
module booth_addsub
  import booth_pkg::*;
#(
  parameter int N = BOOTH_WIDTH + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] m,
  input  op_t          op,
  output logic [N-1:0] sum
);

  // select A+M, A-M or A from the Booth op
  always_comb begin
    sum = a;
    unique case (1'b1)
      (op == OP_ADD): sum = a + m;
      (op == OP_SUB): sum = a - m;
      default:        sum = a;
    endcase
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Radix-2 sequential Booth multiplier, signed operands.
// One Booth step per clock; product registered on the last step.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  st_t              state;
  st_t              state_nxt;
  logic [WIDTH:0]   a_q;
  logic [WIDTH:0]   m_q;
  logic [WIDTH-1:0] q_q;
  logic             q1_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   a_sum;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] q_sh;
  logic             load;
  logic             step;
  logic             last;
  op_t              op;

  assign op = booth_op(q_q[0], q1_q);

  booth_addsub #(
    .N(WIDTH + 1)
  ) u_addsub (
    .a  (a_sum_src()),
    .m  (m_q),
    .op (op),
    .sum(a_sum)
  );

  function automatic logic [WIDTH:0] a_sum_src();
    return a_q;
  endfunction

  assign a_sh = {a_sum[WIDTH], a_sum[WIDTH:1]};
  assign q_sh = {a_sum[0], q_q[WIDTH-1:1]};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state and datapath strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A/Q/Q_1 shift chain, M and iteration counter
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      a_q   <= '0;
      q_q   <= '0;
      q1_q  <= 1'b0;
      m_q   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      a_q   <= '0;
      q_q   <= multiplier;
      q1_q  <= 1'b0;
      m_q   <= {multiplicand[WIDTH-1], multiplicand};
      cnt_q <= CNT_W'(WIDTH);
    end else if (step) begin
      a_q   <= a_sh;
      q_q   <= q_sh;
      q1_q  <= q_q[0];
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // product latches only on the final step
  always_ff @(posedge clk or posedge clr) begin
    if (clr)       product <= '0;
    else if (last) product <= {a_sh[WIDTH-1:0], q_sh};
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed bench for booth_seq_mult (WIDTH=8).
// Vectors, start-ignore, async clear and back-to-back runs.
module tb_booth_seq_mult;

  localparam int W = 8;

  logic           clk;
  logic           clr;
  logic           start;
  logic [W-1:0]   mc;
  logic [W-1:0]   mp;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int total;
  int bad;

  booth_seq_mult #(.WIDTH(W)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .multiplicand(mc),
    .multiplier  (mp),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drive at a negedge, accepted at the following posedge
  task automatic start_op(
    input logic [W-1:0] m,
    input logic [W-1:0] q
  );
    @(negedge clk);
    mc    = m;
    mp    = q;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // count negedges after acceptance until done, bounded
  task automatic wait_done(
    output int lat,
    output int bcnt
  );
    lat  = 0;
    bcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  logic [W-1:0]   vm [6];
  logic [W-1:0]   vq [6];
  logic [2*W-1:0] vp [6];

  initial begin
    int lat;
    int bcnt;
    logic [2*W-1:0] prev;
    logic [2*W-1:0] exp_q [$];
    int mi;
    int qi;
    logic [2*W-1:0] e;

    total = 0;
    bad   = 0;
    clr   = 1'b1;
    start = 1'b0;
    mc    = '0;
    mp    = '0;

    vm[0] = 8'h00; vq[0] = 8'hFF; vp[0] = 16'h0000;
    vm[1] = 8'h03; vq[1] = 8'h05; vp[1] = 16'h000F;
    vm[2] = 8'hFD; vq[2] = 8'h05; vp[2] = 16'hFFF1;
    vm[3] = 8'h05; vq[3] = 8'hFD; vp[3] = 16'hFFF1;
    vm[4] = 8'h80; vq[4] = 8'h80; vp[4] = 16'h4000;
    vm[5] = 8'h7F; vq[5] = 8'h80; vp[5] = 16'hC080;

    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_prod", 32'(product), 32'd0);
    @(negedge clk);
    clr = 1'b0;

    for (int k = 0; k < 6; k++) begin
      start_op(vm[k], vq[k]);
      wait_done(lat, bcnt);
      check($sformatf("lat%0d", k), 32'(lat), 32'd9);
      check($sformatf("busy%0d", k), 32'(bcnt), 32'd9);
      check($sformatf("prod%0d", k), 32'(product), 32'(vp[k]));
      @(negedge clk);
      check($sformatf("dn1_%0d", k), 32'(done), 32'd0);
    end

    // start while busy must be ignored
    prev = product;
    start_op(8'h09, 8'hF9);
    repeat (3) @(negedge clk);
    mc    = 8'h64;
    mp    = 8'h64;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    check("ign_hold", 32'(product), 32'(prev));
    lat = 0;
    for (int i = 5; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      check("ign_hold2", 32'(product), 32'(prev));
    end
    check("ign_lat", 32'(lat), 32'd9);
    check("ign_prod", 32'(product), 32'hFFC1);
    @(negedge clk);

    // async clear mid-operation
    start_op(8'h14, 8'h03);
    repeat (3) @(negedge clk);
    #2;
    clr = 1'b1;
    #1;
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_done", 32'(done), 32'd0);
    check("clr_prod", 32'(product), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    start_op(8'h07, 8'hFA);
    wait_done(lat, bcnt);
    check("clr_lat", 32'(lat), 32'd9);
    check("clr_res", 32'(product), 32'hFFD6);
    @(negedge clk);

    // start held high, random operands, period of 10
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      check("b2b_done", 32'(done), 32'((k % 10) == 9));
      if ((k % 10) == 9) begin
        if (exp_q.size() == 0) begin
          check("b2b_q", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("b2b_prod", 32'(product), 32'(e));
        end
      end
      mc    = W'($urandom);
      mp    = W'($urandom);
      start = 1'b1;
      if ((k % 10) == 0) begin
        mi = int'($signed(mc));
        qi = int'($signed(mp));
        e  = 16'(mi * qi);
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
